// File: rtl/logic_loader_pkg.sv
// logic_loader_pkg: shared command codes, defaults and parser state encoding
// for the logic table loader.
package logic_loader_pkg;
  localparam logic [7:0]  CMD_LOAD     = 8'h01;
  localparam logic [7:0]  CMD_INIT     = 8'h02;
  localparam logic [7:0]  CMD_RUN      = 8'h03;
  localparam logic [7:0]  HDR_BYTE_DEF = 8'hA5;
  localparam logic [15:0] TIMEOUT_DEF  = 16'd50000;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ARG0, S_ARG1, S_PAY, S_CSUM} state_t;
  function automatic logic cmd_valid(input logic [7:0] c);
    return c inside {CMD_LOAD, CMD_INIT, CMD_RUN};
  endfunction
endpackage

// File: rtl/logic_frame_rx.sv
// logic_frame_rx: host byte-stream framer with header detection, XOR checksum
// and inter-byte timeout; reports payload bytes and frame completion.
module logic_frame_rx
  import logic_loader_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_DEF,
  parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output state_t     state,
  output logic [7:0] cmd,
  output logic [7:0] start,
  output logic [9:0] pay_idx,
  output logic       pay_stb,
  output logic       done_stb,
  output logic       csum_ok,
  output logic       err_stb
);
  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d, start_q, start_d, cnt_q, cnt_d, csum_q, csum_d;
  logic [9:0]  k_q, k_d;
  logic [15:0] tmo_q, tmo_d;
  logic        timeout, last, byte_in;
  assign timeout = state_q != S_IDLE && tmo_q == TIMEOUT_CYC;
  // CNT of 0 wraps to 1023 here, giving the full 256-entry load
  assign last    = k_q == {cnt_q - 8'd1, 2'b11};
  assign byte_in = rx_valid && !timeout;
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    csum_d  = byte_in ? csum_q ^ rx_data : csum_q;
    tmo_d   = rx_valid ? '0 : (tmo_q == TIMEOUT_CYC ? tmo_q : tmo_q + 16'd1);
    if (timeout) state_d = S_IDLE;
    else if (rx_valid)
      case (state_q)
        S_IDLE: begin
          csum_d  = '0;
          state_d = rx_data == HDR_BYTE ? S_CMD : S_IDLE;
        end
        S_CMD: begin
          cmd_d   = rx_data;
          state_d = cmd_valid(rx_data) ? S_ARG0 : S_IDLE;
        end
        S_ARG0: begin
          start_d = rx_data;
          state_d = cmd_q == CMD_LOAD ? S_ARG1 : S_CSUM;
        end
        S_ARG1: begin
          cnt_d   = rx_data;
          k_d     = '0;
          state_d = S_PAY;
        end
        S_PAY: begin
          k_d     = k_q + 10'd1;
          state_d = last ? S_CSUM : S_PAY;
        end
        default: state_d = S_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      start_q <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      k_q     <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      k_q     <= k_d;
      tmo_q   <= tmo_d;
    end
  assign state    = state_q;
  assign cmd      = cmd_q;
  assign start    = start_q;
  assign pay_idx  = k_q;
  assign pay_stb  = byte_in && state_q == S_PAY;
  assign done_stb = byte_in && state_q == S_CSUM;
  assign csum_ok  = csum_q == rx_data;
  assign err_stb  = timeout || (byte_in && state_q == S_CMD && !cmd_valid(rx_data));
endmodule

// File: rtl/logic_table_loader.sv
// logic_table_loader: writes host-framed event-table entries into the shadow
// RAM bank, swaps banks while the sequencer idles and issues init/run requests.
module logic_table_loader
  import logic_loader_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_DEF,
  parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       Logic_end,
  output logic [9:0] Logic_Addr,
  output logic [7:0] Logic_Data,
  output logic       Logic_Wren,
  output logic       RAM_sel,
  output logic       RAM_init,
  output logic [7:0] Logic_Init_Ctrl,
  output logic       Logic_Init_wr,
  output logic [7:0] logic_start_addr,
  output logic       Logic_req,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);
  state_t     state;
  logic [7:0] cmd, start;
  logic [9:0] pay_idx;
  logic       pay_stb, done_stb, csum_ok, err_stb;
  logic       good_load, good_init, good_run, swap_go, run_go;
  logic [9:0] addr_q, addr_d;
  logic [7:0] data_q, data_d, ctrl_q, ctrl_d, saddr_q, saddr_d;
  logic       wren_q, wren_d, sel_q, sel_d, init_q, init_d, iwr_q, iwr_d;
  logic       req_q, req_d, ok_q, ok_d, err_q, err_d;
  logic       swap_pend_q, swap_pend_d, run_pend_q, run_pend_d;
  logic_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC), .HDR_BYTE(HDR_BYTE)) u_rx (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .state(state), .cmd(cmd), .start(start), .pay_idx(pay_idx),
    .pay_stb(pay_stb), .done_stb(done_stb), .csum_ok(csum_ok), .err_stb(err_stb)
  );
  assign good_load = done_stb && csum_ok && cmd == CMD_LOAD;
  assign good_init = done_stb && csum_ok && cmd == CMD_INIT;
  assign good_run  = done_stb && csum_ok && cmd == CMD_RUN;
  assign swap_go   = swap_pend_q && Logic_end;
  // a pending swap blocks the request, so the request trails the toggle
  assign run_go    = run_pend_q && !swap_pend_q && Logic_end;
  always_comb begin
    wren_d      = pay_stb;
    addr_d      = pay_stb ? {start, 2'b00} + pay_idx : addr_q;
    data_d      = pay_stb ? rx_data : data_q;
    sel_d       = sel_q ^ swap_go;
    init_d      = init_q && !good_load;
    swap_pend_d = (good_load && !init_q) || (swap_pend_q && !swap_go);
    ctrl_d      = good_init ? start : ctrl_q;
    iwr_d       = good_init;
    saddr_d     = good_run ? start : saddr_q;
    run_pend_d  = good_run || (run_pend_q && !run_go);
    req_d       = run_go;
    ok_d        = done_stb && csum_ok;
    err_d       = err_stb || (done_stb && !csum_ok);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      addr_q      <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
      sel_q       <= 1'b0;
      init_q      <= 1'b1;
      swap_pend_q <= 1'b0;
      ctrl_q      <= '0;
      iwr_q       <= 1'b0;
      saddr_q     <= '0;
      run_pend_q  <= 1'b0;
      req_q       <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      sel_q       <= sel_d;
      init_q      <= init_d;
      swap_pend_q <= swap_pend_d;
      ctrl_q      <= ctrl_d;
      iwr_q       <= iwr_d;
      saddr_q     <= saddr_d;
      run_pend_q  <= run_pend_d;
      req_q       <= req_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
  assign Logic_Addr       = addr_q;
  assign Logic_Data       = data_q;
  assign Logic_Wren       = wren_q;
  assign RAM_sel          = sel_q;
  assign RAM_init         = init_q;
  assign Logic_Init_Ctrl  = ctrl_q;
  assign Logic_Init_wr    = iwr_q;
  assign logic_start_addr = saddr_q;
  assign Logic_req        = req_q;
  assign frame_ok         = ok_q;
  assign frame_err        = err_q;
  assign busy             = state != S_IDLE;
endmodule

// File: tb/tb_logic_table_loader.sv
// tb_logic_table_loader: directed frames checked every cycle against a
// frame-buffer model, plus literal checks on the key scenarios.
module tb_logic_table_loader;
  localparam logic [15:0] T = 16'd64;
  logic       clk = 1'b0, rstn = 1'b1, rx_valid = 1'b0, Logic_end = 1'b0;
  logic [7:0] rx_data = '0;
  logic [9:0] Logic_Addr;
  logic [7:0] Logic_Data, Logic_Init_Ctrl, logic_start_addr;
  logic       Logic_Wren, RAM_sel, RAM_init, Logic_Init_wr, Logic_req, frame_ok, frame_err, busy;

  logic_table_loader #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .Logic_end(Logic_end),
    .Logic_Addr(Logic_Addr), .Logic_Data(Logic_Data), .Logic_Wren(Logic_Wren),
    .RAM_sel(RAM_sel), .RAM_init(RAM_init), .Logic_Init_Ctrl(Logic_Init_Ctrl),
    .Logic_Init_wr(Logic_Init_wr), .logic_start_addr(logic_start_addr), .Logic_req(Logic_req),
    .frame_ok(frame_ok), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_ok = 0, n_err = 0, n_req = 0, n_iwr = 0;
  time sel_t = 0, req_t = 0;
  logic chk_en = 1'b0, prev_sel = 1'b0;
  logic [18:0] wr_log[$];

  task automatic check(input string nm, input logic [15:0] a, input logic [15:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // model: expected outputs after each edge, derived from the frame buffer
  logic [9:0] e_addr;
  logic [7:0] e_data, e_ctrl, e_start;
  logic       e_wren, e_sel, e_init, e_iwr, e_req, e_ok, e_err, e_busy, m_swap, m_run;
  logic [7:0] fb[$];
  int         idle;

  task automatic model_step();
    logic sw, rn;
    int n, cnt, tot;
    logic [7:0] x;
    sw = m_swap && Logic_end;
    rn = m_run && !m_swap && Logic_end;
    e_wren = 0; e_iwr = 0; e_ok = 0; e_err = 0; e_req = rn;
    if (sw) begin e_sel = !e_sel; m_swap = 0; end
    if (rn) m_run = 0;
    if (e_busy && idle == int'(T)) begin
      e_err = 1; e_busy = 0;
    end else if (rx_valid) begin
      if (!e_busy) begin
        if (rx_data == 8'hA5) begin e_busy = 1; fb.delete(); end
      end else begin
        fb.push_back(rx_data);
        n = fb.size();
        if (!(fb[0] inside {8'h01, 8'h02, 8'h03})) begin
          e_err = 1; e_busy = 0;
        end else begin
          cnt = n >= 3 ? (fb[2] == 8'h00 ? 256 : int'(fb[2])) : 0;
          tot = fb[0] == 8'h01 ? 4 + 4 * cnt : 3;
          if (fb[0] == 8'h01 && n >= 4 && n < tot) begin
            e_wren = 1;
            e_addr = 10'((int'(fb[1]) * 4 + n - 4) % 1024);
            e_data = rx_data;
          end
          if (n == tot) begin
            x = 0;
            for (int i = 0; i < n - 1; i++) x ^= fb[i];
            e_busy = 0;
            if (x != rx_data) e_err = 1;
            else begin
              e_ok = 1;
              if (fb[0] == 8'h01) begin
                if (e_init) e_init = 0; else m_swap = 1;
              end else if (fb[0] == 8'h02) begin
                e_ctrl = fb[1]; e_iwr = 1;
              end else begin
                e_start = fb[1]; m_run = 1;
              end
            end
          end
        end
      end
    end
    idle = rx_valid ? 0 : (idle < int'(T) ? idle + 1 : idle);
  endtask

  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      e_addr = 0; e_data = 0; e_ctrl = 0; e_start = 0;
      e_wren = 0; e_sel = 0; e_init = 1; e_iwr = 0; e_req = 0; e_ok = 0; e_err = 0;
      e_busy = 0; m_swap = 0; m_run = 0; idle = 0;
      fb.delete();
    end else model_step();

  always @(negedge clk) if (chk_en) begin
    check("addr", 16'(Logic_Addr), 16'(e_addr));
    check("data", 16'(Logic_Data), 16'(e_data));
    check("wren", 16'(Logic_Wren), 16'(e_wren));
    check("ram_sel", 16'(RAM_sel), 16'(e_sel));
    check("ram_init", 16'(RAM_init), 16'(e_init));
    check("init_ctrl", 16'(Logic_Init_Ctrl), 16'(e_ctrl));
    check("init_wr", 16'(Logic_Init_wr), 16'(e_iwr));
    check("start_addr", 16'(logic_start_addr), 16'(e_start));
    check("req", 16'(Logic_req), 16'(e_req));
    check("frame_ok", 16'(frame_ok), 16'(e_ok));
    check("frame_err", 16'(frame_err), 16'(e_err));
    check("busy", 16'(busy), 16'(e_busy));
    if (Logic_Wren) wr_log.push_back({RAM_init, Logic_Addr, Logic_Data});
    if (frame_ok) n_ok++;
    if (frame_err) n_err++;
    if (Logic_Init_wr) n_iwr++;
    if (Logic_req) begin n_req++; req_t = $time; end
    if (RAM_sel !== prev_sel) sel_t = $time;
    prev_sel = RAM_sel;
  end

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    send(8'hA5);
    foreach (f[i]) send(f[i]);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] d1[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [9:0] a7[8] = '{10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002, 10'h003};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #2 rstn = 1'b0;
    #1 chk_en = 1'b1;
    check("lit_rst_init", 16'(RAM_init), 16'd1);
    check("lit_rst_sel", 16'(RAM_sel), 16'd0);
    check("lit_rst_busy", 16'(busy), 16'd0);
    @(posedge clk); #1 rstn = 1'b1;
    wait_cyc(2);
    // first LOAD goes to both banks and just clears RAM_init
    q = '{8'h01, 8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h54};
    send_frame(q);
    wait_cyc(3);
    check("lit_t1_nwr", 16'(wr_log.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
      check("lit_t1_addr", 16'(wr_log[i][17:8]), 16'(10'h040 + 10'(i)));
      check("lit_t1_data", 16'(wr_log[i][7:0]), 16'(d1[i]));
      check("lit_t1_init", 16'(wr_log[i][18]), 16'd1);
    end
    check("lit_t1_ram_init", 16'(RAM_init), 16'd0);
    check("lit_t1_sel", 16'(RAM_sel), 16'd0);
    check("lit_t1_ok", 16'(n_ok), 16'd1);
    // second LOAD waits for the sequencer to go idle
    wr_log.delete();
    q = '{8'h01, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    send_frame(q);
    wait_cyc(100);
    check("lit_t2_sel_hold", 16'(RAM_sel), 16'd0);
    Logic_end = 1'b1;
    wait_cyc(2);
    check("lit_t2_sel", 16'(RAM_sel), 16'd1);
    check("lit_t2_init", 16'(wr_log[0][18]), 16'd0);
    check("lit_t2_addr", 16'(wr_log[3][17:8]), 16'h003);
    // LOAD + RUN both pending: swap first, request one cycle later
    Logic_end = 1'b0;
    q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(q);
    q = '{8'h03, 8'h05, 8'h06};
    send_frame(q);
    wait_cyc(5);
    check("lit_t3_noreq", 16'(n_req), 16'd0);
    Logic_end = 1'b1;
    wait_cyc(5);
    check("lit_t3_sel", 16'(RAM_sel), 16'd0);
    check("lit_t3_req", 16'(n_req), 16'd1);
    check("lit_t3_start", 16'(logic_start_addr), 16'h05);
    check("lit_t3_order", 16'(req_t - sel_t), 16'd10);
    // INIT
    q = '{8'h02, 8'h15, 8'h17};
    send_frame(q);
    wait_cyc(3);
    check("lit_t4_ctrl", 16'(Logic_Init_Ctrl), 16'h15);
    check("lit_t4_iwr", 16'(n_iwr), 16'd1);
    check("lit_t4_req", 16'(n_req), 16'd1);
    // checksum off by one
    q = '{8'h01, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
    send_frame(q);
    wait_cyc(3);
    check("lit_t5_err", 16'(n_err), 16'd1);
    check("lit_t5_sel", 16'(RAM_sel), 16'd0);
    check("lit_t5_init", 16'(RAM_init), 16'd0);
    check("lit_t5_req", 16'(n_req), 16'd1);
    check("lit_t5_ok", 16'(n_ok), 16'd5);
    // stall after CMD until timeout, then a fresh frame
    send(8'hA5);
    send(8'h01);
    wait_cyc(int'(T) + 5);
    check("lit_t6_err", 16'(n_err), 16'd2);
    check("lit_t6_busy", 16'(busy), 16'd0);
    q = '{8'h03, 8'h07, 8'h04};
    send_frame(q);
    wait_cyc(4);
    check("lit_t6_req", 16'(n_req), 16'd2);
    check("lit_t6_start", 16'(logic_start_addr), 16'h07);
    check("lit_t6_ok", 16'(n_ok), 16'd6);
    // entry index wraps 255 -> 0
    wr_log.delete();
    q = '{8'h01, 8'hFF, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hF4};
    send_frame(q);
    wait_cyc(4);
    check("lit_t7_nwr", 16'(wr_log.size()), 16'd8);
    for (int i = 0; i < 8; i++) begin
      check("lit_t7_addr", 16'(wr_log[i][17:8]), 16'(a7[i]));
      check("lit_t7_data", 16'(wr_log[i][7:0]), 16'(i + 1));
    end
    check("lit_t7_sel", 16'(RAM_sel), 16'd1);
    check("lit_t7_ok", 16'(n_ok), 16'd7);
    // reset mid-frame
    Logic_end = 1'b0;
    send(8'hA5); send(8'h01); send(8'h00); send(8'h01); send(8'h11);
    #3 rstn = 1'b0;
    @(posedge clk); #1;
    check("lit_t8_busy", 16'(busy), 16'd0);
    check("lit_t8_init", 16'(RAM_init), 16'd1);
    check("lit_t8_sel", 16'(RAM_sel), 16'd0);
    check("lit_t8_start", 16'(logic_start_addr), 16'd0);
    rstn = 1'b1;
    wait_cyc(2);
    q = '{8'h02, 8'h0A, 8'h08};
    send_frame(q);
    wait_cyc(3);
    check("lit_t8_ctrl", 16'(Logic_Init_Ctrl), 16'h0A);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
